// File: rtl/hardware_unbinarize_stream.sv
// hardware_unbinarize_stream
//
// Streaming term decoder for the SKI reduction datapath. Each packed heap
// word (tag in the MSBs, payload below it) is decoded combinationally into
// the reducer's term encoding: a 3-bit constructor followed by two pointer
// fields. Decoded terms are held in a small output FIFO, so heap-read bursts
// are decoupled from reducer stalls. Words with an invalid tag are counted.
//
// Ports:
//   system1000      clock, rising edge
//   system1000_rst  asynchronous active-high reset
//   flush_i         synchronous clear of the FIFO (overrides push/pop)
//   in_word_i       packed heap word, WORD_W = TAG_W + 2*PTR_W bits
//   in_valid_i      in_word_i valid
//   in_ready_o      block can accept a word
//   term_o          decoded term at the FIFO head, TERM_W = 3 + 2*PTR_W bits
//   term_valid_o    term_o valid
//   term_ready_i    consumer accepts term_o
//   err_cnt_o       saturating count of invalid tags accepted
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising clock edge; valid does not depend on ready, and a held
// term_o stays stable until it is taken.
//
// Optional build macro HASKI_UNBIN_DROP_INVALID_EN: when defined, invalid
// words complete their input handshake but are not written to the FIFO.
// When undefined, they are stored as the poison term {3'b111, zeros}.
module hardware_unbinarize_stream #(
  parameter int TAG_W      = 4,
  parameter int PTR_W      = 30,
  parameter int LIT_W      = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int WORD_W    = TAG_W + 2 * PTR_W,
  localparam int TERM_W    = 3 + 2 * PTR_W
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic              flush_i,
  input  logic [WORD_W-1:0] in_word_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [TERM_W-1:0] term_o,
  output logic              term_valid_o,
  input  logic              term_ready_i,
  output logic [15:0]       err_cnt_o
);

  localparam int PAYLOAD_W = 2 * PTR_W;
  localparam int ADDR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = ADDR_W + 1;

  // ---------------- combinational decode ----------------
  logic [TAG_W-1:0]     tag;
  logic [PAYLOAD_W-1:0] payload;
  logic [PAYLOAD_W-1:0] litField;
  logic [TERM_W-1:0]    decTerm;
  logic                 decInvalid;

  always_comb begin
    tag        = in_word_i[WORD_W-1 -: TAG_W];
    payload    = in_word_i[PAYLOAD_W-1:0];
    // Literal sits left-justified in the pointer area, zero padded below.
    litField   = '0;
    litField[PAYLOAD_W-1 -: LIT_W] = payload[LIT_W-1:0];
    decTerm    = '0;
    decInvalid = 1'b0;
    if (tag <= TAG_W'(2)) begin
      decTerm[TERM_W-1 -: 3] = tag[2:0];
    end else if (tag == TAG_W'(3)) begin
      decTerm = {3'b011, payload};
    end else if (tag == TAG_W'(4)) begin
      decTerm = {3'b100, litField};
    end else begin
      decInvalid             = 1'b1;
      decTerm[TERM_W-1 -: 3] = 3'b111;
    end
  end

  // ---------------- output FIFO ----------------
  logic [TERM_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [CNT_W-1:0]  count;
  logic [15:0]       errCnt;
  logic              full;
  logic              empty;
  logic              inFire;
  logic              pushEn;
  logic              popEn;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Ready is held low for the whole time reset is asserted.
  assign in_ready_o = ~system1000_rst & ~full;

  // A handshake during flush is accepted on the wire but discarded.
  assign inFire = in_valid_i & in_ready_o & ~flush_i;
`ifdef HASKI_UNBIN_DROP_INVALID_EN
  assign pushEn = inFire & ~decInvalid;
`else
  assign pushEn = inFire;
`endif
  assign popEn  = ~empty & term_ready_i & ~flush_i;

  assign term_valid_o = ~empty;
  assign term_o       = empty ? '0 : mem[rdPtr];
  assign err_cnt_o    = errCnt;

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      errCnt <= '0;
    end else begin
      if (flush_i) begin
        wrPtr <= '0;
        rdPtr <= '0;
        count <= '0;
      end else begin
        // Depth is a power of two, so pointer overflow is the wrap.
        if (pushEn) wrPtr <= wrPtr + ADDR_W'(1);
        if (popEn)  rdPtr <= rdPtr + ADDR_W'(1);
        count <= count + CNT_W'(pushEn) - CNT_W'(popEn);
      end
      if (inFire && decInvalid && (errCnt != 16'hFFFF)) begin
        errCnt <= errCnt + 16'd1;
      end
    end
  end

  // Storage needs no reset: count gates everything read from it.
  always_ff @(posedge system1000) begin
    if (pushEn) mem[wrPtr] <= decTerm;
  end

endmodule

// File: tb/tb_hardware_unbinarize_stream.sv
module tb_hardware_unbinarize_stream;

  localparam int WORD_W = 64;
  localparam int TERM_W = 63;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  logic [TERM_W-1:0] term;
  logic              term_valid;
  logic              term_ready;
  logic [15:0]       err_cnt;

  int n_checks;
  int n_fail;
  logic [TERM_W-1:0] exp_q[$];

  hardware_unbinarize_stream dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .flush_i        (flush),
    .in_word_i      (in_word),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .term_o         (term),
    .term_valid_o   (term_valid),
    .term_ready_i   (term_ready),
    .err_cnt_o      (err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; outputs are looked at 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_word    = '0;
    flush      = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    term_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (term_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", term_valid); end
    n_checks++;
    if (term !== '0) begin n_fail++; $display("FAIL reset_term got %h want 0", term); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_reset got %0b want 0", in_ready); end
    n_checks++;
    if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_err got %h want 0", err_cnt); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %0b want 1", in_ready); end
  endtask

  task automatic test_app();
    term_ready = 1'b1;
    in_word    = 64'h3000_0000_4000_0002;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (term_valid !== 1'b1) begin n_fail++; $display("FAIL app_valid got %0b want 1", term_valid); end
    n_checks++;
    if (term !== 63'h3000_0000_4000_0002) begin n_fail++; $display("FAIL app_term got %h want 3000000040000002", term); end
    n_checks++;
    if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL app_err got %h want 0", err_cnt); end
    step();
    n_checks++;
    if (term_valid !== 1'b0) begin n_fail++; $display("FAIL app_drained got %0b want 0", term_valid); end
  endtask

  task automatic test_literal();
    term_ready = 1'b1;
    in_word    = 64'h4000_0000_DEAD_BEEF;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (term !== 63'h4DEA_DBEE_F000_0000) begin n_fail++; $display("FAIL lit_term got %h want 4deadbeef0000000", term); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [WORD_W-1:0] words [3];
    bit popped;
    logic [TERM_W-1:0] got;
    words[0] = 64'h0123_4567_89AB_CDEF;
    words[1] = 64'h1FFF_FFFF_FFFF_FFFF;
    words[2] = 64'h2000_0000_0000_0055;
    exp_q.delete();
    exp_q.push_back(63'h0);
    exp_q.push_back(63'h1000_0000_0000_0000);
    exp_q.push_back(63'h2000_0000_0000_0000);
    term_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_word  = words[i];
      in_valid = 1'b1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept%0d got %0b want 1", i, in_ready); end
      step();
    end
    in_word = words[2];
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got %0b want 0", in_ready); end
    step();
    // Head must hold while stalled.
    n_checks++;
    if (term !== 63'h0) begin n_fail++; $display("FAIL b2b_head_stable got %h want 0", term); end
    term_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_pop_ready got %0b want 0", in_ready); end
    for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
      popped = term_valid && term_ready;
      got    = term;
      if (in_valid && in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end else begin
        step();
      end
      if (popped) begin
        n_checks++;
        if (got !== exp_q[0]) begin n_fail++; $display("FAIL b2b_order got %h want %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_timeout got %0d left want 0", exp_q.size()); end
    step();
    n_checks++;
    if (term_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_extra got %0b want 0", term_valid); end
  endtask

  task automatic test_invalid();
    logic [15:0] err_before;
    term_ready = 1'b1;
    err_before = err_cnt;
    in_word    = 64'h6000_0000_0000_1234;
    in_valid   = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL inv_ready got %0b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (err_cnt !== err_before + 16'd1) begin n_fail++; $display("FAIL inv_err got %h want %h", err_cnt, err_before + 16'd1); end
`ifdef HASKI_UNBIN_DROP_INVALID_EN
    n_checks++;
    if (term_valid !== 1'b0) begin n_fail++; $display("FAIL inv_dropped got %0b want 0", term_valid); end
`else
    n_checks++;
    if (term_valid !== 1'b1) begin n_fail++; $display("FAIL inv_poison_valid got %0b want 1", term_valid); end
    n_checks++;
    if (term !== 63'h7000_0000_0000_0000) begin n_fail++; $display("FAIL inv_poison got %h want 7000000000000000", term); end
`endif
    step();
  endtask

  task automatic test_flush();
    logic [15:0] err_before;
    err_before = err_cnt;
    term_ready = 1'b0;
    in_valid   = 1'b1;
    in_word    = 64'h3000_0000_4000_0002;
    step();
    in_word    = 64'h4000_0000_1234_5678;
    step();
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_prefull got %0b want 0", in_ready); end
    in_word = 64'h1000_0000_0000_0000;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (term_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", term_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %0b want 1", in_ready); end
    n_checks++;
    if (err_cnt !== err_before) begin n_fail++; $display("FAIL flush_err got %h want %h", err_cnt, err_before); end
    // Handshake completing in a flush cycle while not full is also dropped.
    term_ready = 1'b1;
    in_valid   = 1'b1;
    in_word    = 64'h2000_0000_0000_0000;
    flush      = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (term_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got %0b want 0", term_valid); end
    step();
    n_checks++;
    if (term_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_late got %0b want 0", term_valid); end
  endtask

  task automatic test_async_reset();
    term_ready = 1'b0;
    in_valid   = 1'b1;
    in_word    = 64'h1000_0000_0000_0000;
    step();
    in_word    = 64'h2000_0000_0000_0000;
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (term_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %0b want 0", term_valid); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready got %0b want 0", in_ready); end
    n_checks++;
    if (term !== '0) begin n_fail++; $display("FAIL arst_term got %h want 0", term); end
    step();
    rst = 1'b0;
    #1;
    term_ready = 1'b1;
    in_valid   = 1'b1;
    in_word    = 64'h3000_0000_C000_0007;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (term !== 63'h3000_0000_C000_0007) begin n_fail++; $display("FAIL arst_first got %h want 30000000c0000007", term); end
    n_checks++;
    if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL arst_err got %h want 0", err_cnt); end
    step();
    n_checks++;
    if (term_valid !== 1'b0) begin n_fail++; $display("FAIL arst_alone got %0b want 0", term_valid); end
  endtask

  task automatic test_saturation();
    int accepted;
    term_ready = 1'b1;
    in_word    = 64'hF000_0000_0000_0000;
    in_valid   = 1'b1;
    accepted   = 0;
    for (int i = 0; i < 70000 && accepted < 32'h1_0004; i++) begin
      if (in_ready) accepted++;
      step();
      if (accepted == 32'hFFFE && in_ready) begin
        n_checks++;
        if (err_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got %h want fffe", err_cnt); end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (accepted != 32'h1_0004) begin n_fail++; $display("FAIL sat_timeout got %0d accepts want %0d", accepted, 32'h1_0004); end
    n_checks++;
    if (err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", err_cnt); end
    step();
    step();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    term_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_app();
    test_literal();
    test_back_to_back();
    test_invalid();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hardware_unbinarize_stream.md
Name: hardware_unbinarize_stream

Overview:
Streaming, parametrised term decoder for the SKI reduction datapath. Takes packed heap words (tag field plus payload) over a valid/ready input and converts each into the tagged term encoding used by the reducer: a 3-bit constructor plus two pointer fields. Decoded terms are buffered in a small output FIFO so heap-read bursts decouple from reducer stalls. Invalid tags are counted. It sits between the heap read port and the reducer's term input.

Parameters:
TAG_W, 4, tag field width (MSBs of the input word); must be >= 3
PTR_W, 30, pointer field width; term width TERM_W = 3 + 2*PTR_W
LIT_W, 32, literal payload width; must be <= 2*PTR_W
FIFO_DEPTH, 2, output buffer entries; power of two, >= 2
Derived: WORD_W = TAG_W + 2*PTR_W (default 64); TERM_W (default 63)

Ports:
system1000  in  1  clock, rising edge
system1000_rst  in  1  reset, asynchronous, active-high
flush_i  in  1  synchronous clear of buffer contents
in_word_i  in  WORD_W  packed heap word
in_valid_i  in  1  in_word_i valid
in_ready_o  out  1  block can accept a word
term_o  out  TERM_W  decoded term at FIFO head
term_valid_o  out  1  term_o valid
term_ready_i  in  1  consumer accepts term_o
err_cnt_o  out  16  saturating count of invalid tags seen

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers and count 0, err_cnt_o=0, term_valid_o=0, term_o=0, in_ready_o=0 while reset is asserted and 1 on the first cycle after release.
- Push on in_valid_i && in_ready_o. Pop on term_valid_o && term_ready_i. in_ready_o = (count != FIFO_DEPTH). No bypass: an accepted word appears on term_o no earlier than the next cycle (latency 1 when empty).
- Full with pop in the same cycle: in_ready_o stays 0 that cycle. No push is accepted. count decrements.
- Empty: term_valid_o=0, term_o=0. Push and pop in the same cycle with count between 1 and DEPTH-1: count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH. term_o is driven from the head entry and stays stable while term_valid_o=1 and term_ready_i=0.
- flush_i (priority over push/pop): next cycle count=0 and pointers=0. An input handshake in the flush cycle is dropped. err_cnt_o is not cleared.
- Decode, with tag = in_word_i[WORD_W-1 -: TAG_W] and payload P = in_word_i[2*PTR_W-1:0]:
  - tag 0/1/2 (S, K, I): term = {tag[2:0], all zeros}.
  - tag 3 (application): term = {3'b011, P[2*PTR_W-1:PTR_W], P[PTR_W-1:0]}.
  - tag 4 (literal): term = {3'b100, P[LIT_W-1:0], (2*PTR_W-LIT_W) zeros}.
  - tag >= 5: invalid; handling is set by the optional feature.
- err_cnt_o increments by 1 per accepted invalid word and saturates at 0xFFFF. It does not wrap.
- Decode is combinational on the input. The FIFO stores decoded terms, not raw words.

Optional Feature:
HASKI_UNBIN_DROP_INVALID_EN
- Defined: invalid words are consumed (in_ready_o handshake completes) but not written to the FIFO. err_cnt_o increments.
- Not defined: invalid words are written as term {3'b111, all zeros}, a poison term. err_cnt_o still increments.
- Valid-tag behaviour is identical in both builds.

Test Plan:
- Reset release, push 0x3000_0000_4000_0002, term_ready_i=1 -> next cycle term_valid_o=1, term_o=0x3000_0000_4000_0002 (app, ptrs 1 and 2), err_cnt_o=0.
- Push literal 0x4000_0000_DEAD_BEEF -> term_o=0x4DEA_DBEE_F000_0000.
- term_ready_i=0, push tags 0,1,2 back-to-back -> first two accepted, in_ready_o=0 on the third. Raise term_ready_i -> terms 0x0, 0x1000_0000_0000_0000, 0x2000_0000_0000_0000 emerge in order with no loss.
- Push tag 6 word -> err_cnt_o=1. With macro: no output term. Without macro: term_o=0x7000_0000_0000_0000. Force 0x10000 invalid words -> err_cnt_o holds 0xFFFF.
- FIFO full, assert flush_i with in_valid_i=1 -> next cycle term_valid_o=0 and in_ready_o=1. The flush-cycle word never appears. err_cnt_o unchanged.
- Assert system1000_rst asynchronously while two entries are buffered -> term_valid_o=0 immediately. After release, the first pushed word emerges alone.
